basic_control_unit: RTL

Hardwired control unit for the 16-bit basic computer. It decodes the 4-bit T-state from the timing counter, the instruction register, flags and the interrupt request. It produces the counter's increment and clear strobes, plus every register, bus, memory and ALU control signal for one instruction per sequence. It holds the sequencing state: interrupt cycle flag R, indirect bit I, IEN and halt.

---
 rtl/basic_ctrl_pkg.sv | 62 ++++++
 rtl/basic_ctrl_decode.sv | 16 +
 rtl/basic_control_unit.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/basic_ctrl_pkg.sv
// Shared encodings for the basic-computer hardwired control unit.
package basic_ctrl_pkg;

  // Common-bus source select codes
  localparam logic [2:0] BUS_NONE = 3'd0;
  localparam logic [2:0] BUS_AR   = 3'd1;
  localparam logic [2:0] BUS_PC   = 3'd2;
  localparam logic [2:0] BUS_DR   = 3'd3;
  localparam logic [2:0] BUS_AC   = 3'd4;
  localparam logic [2:0] BUS_IR   = 3'd5;
  localparam logic [2:0] BUS_TR   = 3'd6;
  localparam logic [2:0] BUS_MEM  = 3'd7;

  // AC operation codes, meaningful while ld_ac is asserted
  localparam logic [3:0] ALU_NOP     = 4'd0;
  localparam logic [3:0] ALU_AND     = 4'd1;
  localparam logic [3:0] ALU_ADD     = 4'd2;
  localparam logic [3:0] ALU_PASS_DR = 4'd3;
  localparam logic [3:0] ALU_CMA     = 4'd4;
  localparam logic [3:0] ALU_CIR     = 4'd5;
  localparam logic [3:0] ALU_CIL     = 4'd6;
  localparam logic [3:0] ALU_INPR    = 4'd7;

  // Opcode field values (D index); 7 selects register-reference / I/O
  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_LDA = 3'd2;
  localparam logic [2:0] OP_STA = 3'd3;
  localparam logic [2:0] OP_BUN = 3'd4;
  localparam logic [2:0] OP_BSA = 3'd5;
  localparam logic [2:0] OP_ISZ = 3'd6;
  localparam logic [2:0] OP_REG = 3'd7;

  // Register-reference bit positions within the address field
  localparam int unsigned RR_CLA = 11;
  localparam int unsigned RR_CLE = 10;
  localparam int unsigned RR_CMA = 9;
  localparam int unsigned RR_CME = 8;
  localparam int unsigned RR_CIR = 7;
  localparam int unsigned RR_CIL = 6;
  localparam int unsigned RR_INC = 5;
  localparam int unsigned RR_SPA = 4;
  localparam int unsigned RR_SNA = 3;
  localparam int unsigned RR_SZA = 2;
  localparam int unsigned RR_SZE = 1;
  localparam int unsigned RR_HLT = 0;

  // I/O instruction bit positions within the address field
  localparam int unsigned IO_INP = 11;
  localparam int unsigned IO_OUT = 10;
  localparam int unsigned IO_SKI = 9;
  localparam int unsigned IO_SKO = 8;
  localparam int unsigned IO_ION = 7;
  localparam int unsigned IO_IOF = 6;

  // One-hot timing and opcode decode bundle
  typedef struct packed {
    logic [15:0] t;
    logic [7:0]  d;
  } decode_t;

endpackage

// File: rtl/basic_ctrl_decode.sv
// Combinational T-state and opcode one-hot decoder.
module basic_ctrl_decode
  import basic_ctrl_pkg::*;
(
  input  logic [3:0] state_counter,
  input  logic [2:0] opcode,
  output decode_t    dec
);

  // One-hot expansion of the timing state and the opcode field
  always_comb begin
    dec.t = 16'd1 << state_counter;
    dec.d = 8'd1 << opcode;
  end

endmodule

// File: rtl/basic_control_unit.sv
// Hardwired control unit for the 16-bit basic computer.
module basic_control_unit
  import basic_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int OPC_LSB = 12
) (
  input  logic        clk_controller,
  input  logic        rst_controller,
  input  logic [3:0]  state_counter,
  input  logic [15:0] ir,
  input  logic        ac_zero,
  input  logic        ac_neg,
  input  logic        e_flag,
  input  logic        dr_zero,
  input  logic        fgi,
  input  logic        fgo,
  output logic        inc_controller_counter,
  output logic        clr_controller_counter,
  output logic [2:0]  bus_sel,
  output logic        ld_ar,
  output logic        inc_ar,
  output logic        clr_ar,
  output logic        ld_pc,
  output logic        inc_pc,
  output logic        clr_pc,
  output logic        ld_dr,
  output logic        inc_dr,
  output logic        ld_ac,
  output logic        inc_ac,
  output logic        clr_ac,
  output logic        ld_ir,
  output logic        ld_tr,
  output logic        mem_wr,
  output logic        clr_e,
  output logic        cme,
  output logic        ld_outr,
  output logic        clr_fgi,
  output logic        clr_fgo,
  output logic [3:0]  alu_op,
  output logic        halted,
  output logic        ien_out
);

  decode_t           dec;
  logic [ADDR_W-1:0] fld;
  logic              r_q, r_d, i_q, i_d, ien_q, ien_d, halt_q, halt_d;
  logic              active, rr_t3, io_t3;

  basic_ctrl_decode u_decode (
    .state_counter (state_counter),
    .opcode        (ir[OPC_LSB +: 3]),
    .dec           (dec)
  );

  assign fld    = ir[ADDR_W-1:0];
  // T7..T15 never carry an action; T15 in particular flags a missed clr
  assign active = ~rst_controller & ~halt_q & ~(|dec.t[15:7]);
  assign rr_t3  = dec.t[3] & dec.d[OP_REG] & ~i_q;
  assign io_t3  = dec.t[3] & dec.d[OP_REG] & i_q;

  // Datapath strobes; execution from T3 on ignores R (R only steers T0..T2)
  always_comb begin
    clr_controller_counter = 1'b0;
    bus_sel = BUS_NONE;
    alu_op  = ALU_NOP;
    {ld_ar, inc_ar, clr_ar, ld_pc, inc_pc, clr_pc, ld_dr, inc_dr} = '0;
    {ld_ac, inc_ac, clr_ac, ld_ir, ld_tr, mem_wr, clr_e, cme}     = '0;
    {ld_outr, clr_fgi, clr_fgo}                                   = '0;
    if (active) begin
      if (r_q) begin
        if (dec.t[0]) begin clr_ar = 1'b1; bus_sel = BUS_PC; ld_tr = 1'b1; end
        if (dec.t[1]) begin bus_sel = BUS_TR; mem_wr = 1'b1; clr_pc = 1'b1; end
        if (dec.t[2]) begin inc_pc = 1'b1; clr_controller_counter = 1'b1; end
      end else begin
        if (dec.t[0]) begin bus_sel = BUS_PC; ld_ar = 1'b1; end
        if (dec.t[1]) begin bus_sel = BUS_MEM; ld_ir = 1'b1; inc_pc = 1'b1; end
        if (dec.t[2]) begin bus_sel = BUS_IR; ld_ar = 1'b1; end
      end
      if (dec.t[3] & ~dec.d[OP_REG] & i_q) begin
        bus_sel = BUS_MEM; ld_ar = 1'b1;
      end
      if (rr_t3) begin
        clr_controller_counter = 1'b1;
        clr_ac = fld[RR_CLA];
        clr_e  = fld[RR_CLE];
        cme    = fld[RR_CME];
        inc_ac = fld[RR_INC];
        if (fld[RR_CMA])      begin ld_ac = 1'b1; alu_op = ALU_CMA; end
        else if (fld[RR_CIR]) begin ld_ac = 1'b1; alu_op = ALU_CIR; end
        else if (fld[RR_CIL]) begin ld_ac = 1'b1; alu_op = ALU_CIL; end
        inc_pc = (fld[RR_SPA] & ~ac_neg) | (fld[RR_SNA] & ac_neg) |
                 (fld[RR_SZA] & ac_zero) | (fld[RR_SZE] & ~e_flag);
      end
      if (io_t3) begin
        clr_controller_counter = 1'b1;
        if (fld[IO_INP]) begin alu_op = ALU_INPR; ld_ac = 1'b1; clr_fgi = 1'b1; end
        if (fld[IO_OUT]) begin bus_sel = BUS_AC; ld_outr = 1'b1; clr_fgo = 1'b1; end
        inc_pc = (fld[IO_SKI] & fgi) | (fld[IO_SKO] & fgo);
      end
      if (dec.t[4]) begin
        if (dec.d[OP_AND] | dec.d[OP_ADD] | dec.d[OP_LDA] | dec.d[OP_ISZ]) begin
          bus_sel = BUS_MEM; ld_dr = 1'b1;
        end
        if (dec.d[OP_STA]) begin
          bus_sel = BUS_AC; mem_wr = 1'b1; clr_controller_counter = 1'b1;
        end
        if (dec.d[OP_BUN]) begin
          bus_sel = BUS_AR; ld_pc = 1'b1; clr_controller_counter = 1'b1;
        end
        if (dec.d[OP_BSA]) begin
          bus_sel = BUS_PC; mem_wr = 1'b1; inc_ar = 1'b1;
        end
      end
      if (dec.t[5]) begin
        if (dec.d[OP_AND] | dec.d[OP_ADD] | dec.d[OP_LDA]) begin
          ld_ac = 1'b1; clr_controller_counter = 1'b1;
          alu_op = dec.d[OP_AND] ? ALU_AND : (dec.d[OP_ADD] ? ALU_ADD : ALU_PASS_DR);
        end
        if (dec.d[OP_BSA]) begin
          bus_sel = BUS_AR; ld_pc = 1'b1; clr_controller_counter = 1'b1;
        end
        if (dec.d[OP_ISZ]) inc_dr = 1'b1;
      end
      if (dec.t[6] & dec.d[OP_ISZ]) begin
        bus_sel = BUS_DR; mem_wr = 1'b1; inc_pc = dr_zero;
        clr_controller_counter = 1'b1;
      end
    end
  end

  assign inc_controller_counter = ~halt_q & ~clr_controller_counter & ~rst_controller;
  assign halted  = halt_q;
  assign ien_out = ien_q;

  // Next sequencing state: I latch, interrupt detect/service, IEN, halt
  always_comb begin
    r_d    = r_q;
    i_d    = i_q;
    ien_d  = ien_q;
    halt_d = halt_q;
    if (~halt_q) begin
      if (~r_q & dec.t[2]) i_d = ir[15];
      if (~(dec.t[0] | dec.t[1] | dec.t[2]) & ien_q & (fgi | fgo)) r_d = 1'b1;
      if (r_q & dec.t[2]) begin
        r_d   = 1'b0;
        ien_d = 1'b0;
      end
      if (rr_t3 & fld[RR_HLT]) halt_d = 1'b1;
      if (io_t3 & fld[IO_ION]) ien_d = 1'b1;
      if (io_t3 & fld[IO_IOF]) ien_d = 1'b0;
    end
  end

  // Sequencing flags with synchronous reset
  always_ff @(posedge clk_controller) begin
    if (rst_controller) begin
      r_q    <= 1'b0;
      i_q    <= 1'b0;
      ien_q  <= 1'b0;
      halt_q <= 1'b0;
    end else begin
      r_q    <= r_d;
      i_q    <= i_d;
      ien_q  <= ien_d;
      halt_q <= halt_d;
    end
  end

endmodule
